// File: rtl/next_workday_walker_if.sv
// Request/response bundle for next_workday_walker: request fields travel with start,
// and the result fields are valid while done is high.
interface next_workday_walker_if #(
    parameter int unsigned NW = 4
);
    logic          start;
    logic [4:0]    date_in;
    logic [2:0]    week_in;
    logic [NW-1:0] n_in;
    logic [4:0]    dim_in;
    logic [31:0]   hol_mask;
    logic          busy;
    logic          done;
    logic          err;
    logic [4:0]    date_out;
    logic [2:0]    week_out;
    logic [1:0]    month_wrap;

    modport master (
        output start, date_in, week_in, n_in, dim_in, hol_mask,
        input  busy, done, err, date_out, week_out, month_wrap
    );

    modport slave (
        input  start, date_in, week_in, n_in, dim_in, hol_mask,
        output busy, done, err, date_out, week_out, month_wrap
    );
endinterface

// File: rtl/next_workday_walker.sv
// Walks forward one calendar day per clock until N working days have passed, skipping
// weekend days and (within the requesting month only) holidays.
module next_workday_walker #(
    parameter int unsigned NW           = 4,
    parameter logic [6:0]  WEEKEND_MASK = 7'b1100000
) (
    input logic                 clk,
    input logic                 rst,
    next_workday_walker_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StWalk, StDone} state_e;

    state_e        state_q, state_d;
    logic [4:0]    date_q, date_d, dim_q, dim_d;
    logic [2:0]    week_q, week_d;
    logic [NW-1:0] n_q, n_d, cnt_q, cnt_d;
    logic [31:0]   hol_q, hol_d;
    logic [1:0]    wrap_q, wrap_d;
    logic          err_q, err_d;
    logic [4:0]    date_out_q, date_out_d;
    logic [2:0]    week_out_q, week_out_d;
    logic [1:0]    mwrap_q, mwrap_d;

    logic          in_bad;
    logic [4:0]    date_nx;
    logic [2:0]    week_nx, week_idx;
    logic [1:0]    wrap_nx;
    logic          working;

    // Candidate next calendar day and whether it counts as a working day.
    always_comb begin
        in_bad = (bus.date_in == 5'd0) || (bus.date_in > bus.dim_in) ||
                 (bus.week_in == 3'd0) || (bus.dim_in < 5'd28) || (WEEKEND_MASK == 7'h7F);
        if (date_q == dim_q) begin
            date_nx = 5'd1;
            wrap_nx = (wrap_q == 2'd3) ? 2'd3 : wrap_q + 2'd1;
        end else begin
            date_nx = date_q + 5'd1;
            wrap_nx = wrap_q;
        end
        week_nx  = (week_q == 3'd7) ? 3'd1 : week_q + 3'd1;
        week_idx = week_nx - 3'd1;
        // The holiday bitmap describes the requesting month only.
        working  = !WEEKEND_MASK[week_idx] && ((wrap_nx != 2'd0) || !hol_q[date_nx]);
    end

    always_comb begin
        state_d    = state_q;
        date_d     = date_q;
        dim_d      = dim_q;
        week_d     = week_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        hol_d      = hol_q;
        wrap_d     = wrap_q;
        err_d      = err_q;
        date_out_d = date_out_q;
        week_out_d = week_out_q;
        mwrap_d    = mwrap_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    date_d     = bus.date_in;
                    week_d     = bus.week_in;
                    n_d        = bus.n_in;
                    dim_d      = bus.dim_in;
                    hol_d      = bus.hol_mask;
                    cnt_d      = '0;
                    wrap_d     = 2'd0;
                    err_d      = 1'b0;
                    date_out_d = 5'd0;
                    week_out_d = 3'd0;
                    mwrap_d    = 2'd0;
                    if (in_bad) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else if (bus.n_in == '0) begin
                        date_out_d = bus.date_in;
                        week_out_d = bus.week_in;
                        state_d    = StDone;
                    end else begin
                        state_d = StWalk;
                    end
                end
            end
            StWalk: begin
                date_d = date_nx;
                week_d = week_nx;
                wrap_d = wrap_nx;
                if (working) begin
                    cnt_d = cnt_q + NW'(1);
                    if ((cnt_q + NW'(1)) == n_q) begin
                        date_out_d = date_nx;
                        week_out_d = week_nx;
                        mwrap_d    = wrap_nx;
                        state_d    = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            date_q     <= 5'd0;
            dim_q      <= 5'd0;
            week_q     <= 3'd0;
            n_q        <= '0;
            cnt_q      <= '0;
            hol_q      <= 32'd0;
            wrap_q     <= 2'd0;
            err_q      <= 1'b0;
            date_out_q <= 5'd0;
            week_out_q <= 3'd0;
            mwrap_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            date_q     <= date_d;
            dim_q      <= dim_d;
            week_q     <= week_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            hol_q      <= hol_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
            date_out_q <= date_out_d;
            week_out_q <= week_out_d;
            mwrap_q    <= mwrap_d;
        end
    end

    assign bus.busy       = (state_q == StWalk);
    assign bus.done       = (state_q == StDone);
    assign bus.err        = err_q;
    assign bus.date_out   = date_out_q;
    assign bus.week_out   = week_out_q;
    assign bus.month_wrap = mwrap_q;
endmodule

// File: tb/tb_next_workday_walker.sv
// Scoreboard bench: requests push model results into a queue, a monitor pops them on done.
module tb_next_workday_walker;
    localparam int unsigned NW = 4;
    localparam logic [6:0]  WM = 7'b1100000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    next_workday_walker_if #(.NW(NW)) bus ();
    next_workday_walker #(.NW(NW), .WEEKEND_MASK(WM)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic       err;
        logic [4:0] date;
        logic [2:0] week;
        logic [1:0] wrap;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: count calendar days k from today using modular date arithmetic.
    function automatic exp_t model(input logic [4:0] d, input logic [2:0] w,
                                   input logic [NW-1:0] n, input logic [4:0] dim,
                                   input logic [31:0] hol);
        exp_t e;
        int   k, cnt, dd, wk, wr;
        e.err = 1'b0; e.date = 5'd0; e.week = 3'd0; e.wrap = 2'd0; e.cyc = 0;
        if (d == 0 || d > dim || w == 0 || dim < 28 || WM == 7'h7F) begin
            e.err = 1'b1;
            return e;
        end
        if (n == 0) begin
            e.date = d; e.week = w;
            return e;
        end
        k = 0; cnt = 0; dd = 0; wk = 0; wr = 0;
        while (cnt < int'(n)) begin
            k++;
            dd = (int'(d) - 1 + k) % int'(dim) + 1;
            wr = (int'(d) - 1 + k) / int'(dim);
            wk = (int'(w) - 1 + k) % 7 + 1;
            if (!WM[wk-1] && (wr > 0 || !hol[dd])) cnt++;
        end
        e.date = 5'(dd);
        e.week = 3'(wk);
        e.wrap = (wr > 3) ? 2'd3 : 2'(wr);
        e.cyc  = k;
        return e;
    endfunction

    task automatic scramble();
        bus.date_in  = 5'($urandom);
        bus.week_in  = 3'($urandom);
        bus.n_in     = NW'($urandom);
        bus.dim_in   = 5'($urandom);
        bus.hol_mask = $urandom;
    endtask

    // Called at a negedge; waits for IDLE, then holds start across one edge.
    task automatic issue(input logic [4:0] d, input logic [2:0] w, input logic [NW-1:0] n,
                         input logic [4:0] dim, input logic [31:0] hol);
        exp_t e;
        int   t = 0;
        while ((bus.busy || bus.done) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) check("idle_timeout", t, 0);
        bus.date_in = d; bus.week_in = w; bus.n_in = n; bus.dim_in = dim; bus.hol_mask = hol;
        bus.start = 1'b1;
        e = model(d, w, n, dim, hol);
        e.cyc = e.cyc + cyc + 1;
        q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        scramble();
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && bus.done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                check("err", int'(bus.err), int'(e.err));
                check("date_out", int'(bus.date_out), int'(e.date));
                check("week_out", int'(bus.week_out), int'(e.week));
                check("month_wrap", int'(bus.month_wrap), int'(e.wrap));
                check("latency_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_err"}, int'(bus.err), 0);
        check({tag, "_date_out"}, int'(bus.date_out), 0);
        check({tag, "_week_out"}, int'(bus.week_out), 0);
        check({tag, "_month_wrap"}, int'(bus.month_wrap), 0);
    endtask

    initial begin
        exp_t e;
        int   t;
        logic [4:0] dim, d;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.date_in = 5'd0; bus.week_in = 3'd0; bus.n_in = '0; bus.dim_in = 5'd0;
        bus.hol_mask = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        issue(5'd15, 3'd3, 4'd0, 5'd30, 32'd0);
        issue(5'd30, 3'd5, 4'd1, 5'd30, 32'd0);
        issue(5'd10, 3'd1, 4'd2, 5'd31, 32'h0000_0800);
        issue(5'd28, 3'd1, 4'd3, 5'd28, 32'h0000_0006);
        issue(5'd31, 3'd2, 4'd2, 5'd30, 32'd0);
        issue(5'd12, 3'd0, 4'd2, 5'd31, 32'd0);
        issue(5'd12, 3'd2, 4'd2, 5'd27, 32'd0);

        // A start during a walk must be dropped.
        issue(5'd10, 3'd1, 4'd5, 5'd31, 32'd0);
        @(negedge clk);
        bus.date_in = 5'd3; bus.week_in = 3'd2; bus.n_in = 4'd0; bus.dim_in = 5'd30;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;

        // A start held through the done cycle is taken on the following IDLE cycle.
        t = 0;
        while (!bus.done && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) check("done_timeout", t, 0);
        bus.date_in = 5'd20; bus.week_in = 3'd4; bus.n_in = 4'd3; bus.dim_in = 5'd31;
        bus.hol_mask = 32'd0;
        bus.start = 1'b1;
        e = model(5'd20, 3'd4, 4'd3, 5'd31, 32'd0);
        e.cyc = e.cyc + cyc + 2;
        q.push_back(e);
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        scramble();

        // Reset mid-walk aborts with no done.
        issue(5'd1, 3'd1, 4'd15, 5'd31, 32'd0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        check_zero("abort");
        issue(5'd30, 3'd6, 4'd2, 5'd31, 32'd0);

        for (int w = 1; w <= 7; w++) begin
            for (int n = 0; n <= 7; n++) begin
                issue(5'd30, 3'(w), NW'(n), 5'd30, $urandom);
            end
        end

        for (int i = 0; i < 60; i++) begin
            dim = 5'(28 + $urandom_range(0, 3));
            d   = 5'($urandom_range(1, int'(dim)));
            if ($urandom_range(0, 9) == 0) begin
                d   = 5'($urandom);
                dim = 5'($urandom);
            end
            issue(d, 3'($urandom_range(0, 7)), NW'($urandom), dim, $urandom);
        end

        t = 0;
        while (q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", q.size(), 0);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/next_workday_walker.md
Name: next_workday_walker

Overview:
- Sequential, parametrised successor to the combinational next-working-day calculator.
- Given today's date, day-of-week, month length and a holiday bitmap, it walks forward one calendar day per clock until N working days have elapsed.
- Returns the resulting date and weekday, plus a month-wrap count.
- Sits in the calendar/scheduling path.
- Start/done handshake: one request in flight at a time.

Parameters:
- NW, 4: width of n_in (max request 2^NW-1 working days).
- WEEKEND_MASK, 7'b1100000: bit (w-1) set means weekday w is non-working (1=Mon..7=Sun; default Sat/Sun).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe; accepted only when busy=0.
- date_in  in  5  today's date, 1..dim_in.
- week_in  in  3  today's weekday, 1..7.
- n_in  in  NW  working days ahead.
- dim_in  in  5  days in current month, 28..31.
- hol_mask  in  32  bit d set means date d of the current month is a holiday (bit 0 unused).
- busy  out  1  walk in progress.
- done  out  1  one-cycle result strobe.
- err  out  1  valid only with done; request rejected.
- date_out  out  5  result date.
- week_out  out  3  result weekday.
- month_wrap  out  2  month boundaries crossed; saturates at 3.

Behaviour:
- Reset (sync, rst=1 at clk edge): state IDLE; busy=0, done=0, err=0, date_out=0, week_out=0, month_wrap=0. rst has priority over start and aborts any walk in progress with no done.
- States: IDLE, WALK, DONE.
- IDLE:
  - On start=1, register date_in, week_in, n_in, dim_in and hol_mask, and clear the working-day count cnt and the wrap counter.
  - If any input is invalid: go to DONE with err=1, date_out=0, week_out=0. Invalid means date_in=0, date_in>dim_in, week_in=0, dim_in<28, dim_in>31, or WEEKEND_MASK=7'h7F.
  - Else if n_in=0: go to DONE with date_out=date_in, week_out=week_in, whether or not today is working.
  - Else go to WALK with busy=1.
- WALK, one calendar day per cycle:
  - date increments; date==dim advances to 1, and the wrap counter increments (saturating).
  - week increments; 7 advances to 1.
  - The new day is working if its WEEKEND_MASK bit is 0 and, only while no wrap has occurred, its hol_mask bit is 0. Holidays apply to the requesting month only.
  - On a working day, cnt increments; when cnt reaches n, load date_out/week_out/month_wrap and go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. Outputs hold until the next accepted start or reset.
- Latency: done rises D+1 cycles after the start edge, where D = calendar days advanced. Errors and n_in=0 give D=0.
- start while busy=1 or in DONE is ignored (not queued).
- start in the same cycle done is high is ignored; it is accepted on the following IDLE cycle.
- Request inputs are sampled only at acceptance; later changes have no effect.
- Arithmetic: date/week registers are 5/3 bits with explicit compare-and-wrap. No modular operator. No combinational path from inputs to outputs.

Test Plan:
- Reset and N=0: rst, then start date_in=15, week_in=3, n_in=0, dim_in=30 -> done one cycle after start; date_out=15, week_out=3, err=0, month_wrap=0.
- Weekend skip plus month wrap: date_in=30, week_in=5 (Fri), n_in=1, dim_in=30, hol_mask=0 -> done 4 cycles after start; date_out=3, week_out=1, month_wrap=1.
- Holiday skip: date_in=10, week_in=1, n_in=2, dim_in=31, hol_mask bit11=1 -> date_out=13, week_out=4, done 4 cycles after start.
- Holiday ignored after wrap: date_in=28, week_in=1, n_in=3, dim_in=28, hol_mask bits 1,2=1 -> date_out=3, week_out=4, month_wrap=1.
- Error handling: date_in=31 with dim_in=30 -> done and err=1 one cycle after start, date_out=0. Separately, week_in=0 -> err=1.
- Busy and reset: issue a second start during a walk -> ignored, first result unchanged. Assert rst mid-WALK -> next cycle busy=0, no done, all outputs 0; a new start afterwards completes normally.
- Sweep (bench loop): for every week_in 1..7 and n_in 0..7 at date_in=30, dim_in=30, compare against a reference model.
